// File: rtl/sobolrng_seq_ctrl_pkg.sv
// Shared definitions for Sobol sequence controllers.
// Latency: n/a (types, constants and a pure combinational helper).
// Backpressure: n/a.
//   STATE_* / state_e : controller state encoding (IDLE, RUN, DONE)
//   lzb_onehot()      : one-hot of the lowest zero bit of an index
package sobolrng_seq_ctrl_pkg;

  // Widest index the helper function supports; callers cast in/out of this.
  localparam int SOBOL_MAXW = 32;

  localparam logic [1:0] STATE_IDLE = 2'd0;
  localparam logic [1:0] STATE_RUN  = 2'd1;
  localparam logic [1:0] STATE_DONE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = STATE_IDLE,
    ST_RUN  = STATE_RUN,
    ST_DONE = STATE_DONE
  } state_e;

  // ~k & (k+1) isolates the lowest zero bit of k. When the caller's index is
  // all ones, the set bit lands above the caller's width and truncation
  // yields zero, so the core holds on the final sample of a full period.
  function automatic logic [SOBOL_MAXW-1:0] lzb_onehot(input logic [SOBOL_MAXW-1:0] k);
    return ~k & (k + 32'd1);
  endfunction

endpackage

// File: rtl/sobolrng_core.sv
// Sobol RNG core: XORs the selected direction vector into the running sample.
// Latency: one cycle from iEn/iClr to updated oRand.
// Backpressure: none; holds its value whenever iEn=0 and iClr=0.
//   iClk, iRstN : clock, async active-low reset
//   iEn, iClr   : step / clear (clear has priority)
//   iOneHot     : direction-vector select, one-hot or zero
//   dirVec      : packed direction vectors, v_i at [(i+1)*BITWIDTH-1 : i*BITWIDTH]
//   oRand       : current sample
module sobolrng_core #(
  parameter int BITWIDTH = 8
) (
  input  logic                         iClk,
  input  logic                         iRstN,
  input  logic                         iEn,
  input  logic                         iClr,
  input  logic [BITWIDTH-1:0]          iOneHot,
  input  logic [BITWIDTH*BITWIDTH-1:0] dirVec,
  output logic [BITWIDTH-1:0]          oRand
);

  logic [BITWIDTH-1:0] rand_q;
  logic [BITWIDTH-1:0] rand_d;
  logic [BITWIDTH-1:0] sel_vec;

  // OR of the selected vectors; with a one-hot select this is exactly v_i.
  always_comb begin
    sel_vec = '0;
    for (int i = 0; i < BITWIDTH; i++) begin
      if (iOneHot[i]) begin
        sel_vec = sel_vec | dirVec[i*BITWIDTH +: BITWIDTH];
      end
    end
  end

  always_comb begin
    rand_d = rand_q;
    if (iClr) begin
      rand_d = '0;
    end else if (iEn) begin
      rand_d = rand_q ^ sel_vec;
    end
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      rand_q <= '0;
    end else begin
      rand_q <= rand_d;
    end
  end

  assign oRand = rand_q;

endmodule

// File: rtl/sobolrng_seq_ctrl.sv
// Sequencer emitting a run of iLen consecutive Sobol samples from one core.
// Latency: first sample valid the cycle after start; 1 sample/cycle with iReady high.
// Backpressure: iReady=0 stalls indefinitely; oRand/oIdx/oValid hold.
//   iClk, iRstN   : clock, async active-low reset
//   iStart, iLen  : start a run of iLen (1..2^BITWIDTH) samples, IDLE only
//   iStop         : abort the current run (no oDone)
//   dirVec        : direction vectors, stable while oBusy
//   iReady        : downstream accepts oRand
//   oRand, oValid : sample and its valid
//   oIdx          : sample index k
//   oBusy, oDone  : run in progress / one-cycle completion pulse
module sobolrng_seq_ctrl
  import sobolrng_seq_ctrl_pkg::*;
#(
  parameter int BITWIDTH = 8
) (
  input  logic                         iClk,
  input  logic                         iRstN,
  input  logic                         iStart,
  input  logic                         iStop,
  input  logic [BITWIDTH:0]            iLen,
  input  logic [BITWIDTH*BITWIDTH-1:0] dirVec,
  input  logic                         iReady,
  output logic [BITWIDTH-1:0]          oRand,
  output logic                         oValid,
  output logic [BITWIDTH-1:0]          oIdx,
  output logic                         oBusy,
  output logic                         oDone
);

  localparam logic [BITWIDTH-1:0] K_ONE   = BITWIDTH'(1);
  localparam logic [BITWIDTH:0]   REM_ONE = (BITWIDTH+1)'(1);

  state_e              state_q, state_d;
  logic [BITWIDTH-1:0] k_q, k_d;
  logic [BITWIDTH:0]   rem_q, rem_d;

  logic                core_en;
  logic                core_clr;
  logic [BITWIDTH-1:0] core_onehot;
  logic [BITWIDTH-1:0] k_onehot;

  assign k_onehot = BITWIDTH'(lzb_onehot(SOBOL_MAXW'(k_q)));

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    rem_d       = rem_q;
    core_en     = 1'b0;
    core_clr    = 1'b0;
    core_onehot = '0;
    unique case (state_q)
      ST_IDLE: begin
        // A zero-length start is dropped rather than producing an empty run.
        if (iStart && (iLen != '0)) begin
          core_clr = 1'b1;
          k_d      = '0;
          rem_d    = iLen;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        // oValid is high throughout RUN, so iReady alone marks a handshake.
        if (iReady) begin
          core_en     = 1'b1;
          core_onehot = k_onehot;
          k_d         = k_q + K_ONE;
          rem_d       = rem_q - REM_ONE;
          if (rem_q == REM_ONE) begin
            state_d = ST_DONE;
          end
        end
        // Abort overrides completion: a stopped run never reports oDone.
        if (iStop) begin
          state_d = ST_IDLE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      rem_q   <= rem_d;
    end
  end

  sobolrng_core #(
    .BITWIDTH (BITWIDTH)
  ) u_core (
    .iClk    (iClk),
    .iRstN   (iRstN),
    .iEn     (core_en),
    .iClr    (core_clr),
    .iOneHot (core_onehot),
    .dirVec  (dirVec),
    .oRand   (oRand)
  );

  // All outputs decode registered state only.
  assign oValid = (state_q == ST_RUN);
  assign oBusy  = (state_q == ST_RUN);
  assign oDone  = (state_q == ST_DONE);
  assign oIdx   = k_q;

endmodule

// File: tb/tb_sobolrng_seq_ctrl.sv
module tb_sobolrng_seq_ctrl;

  localparam int BW = 4;

  logic          iClk;
  logic          iRstN;
  logic          iStart;
  logic          iStop;
  logic [BW:0]   iLen;
  logic [BW*BW-1:0] dirVec;
  logic          iReady;
  logic [BW-1:0] oRand;
  logic          oValid;
  logic [BW-1:0] oIdx;
  logic          oBusy;
  logic          oDone;

  int n_cmp;
  int n_err;

  // Scoreboard entries: {expected idx, expected rand}.
  logic [2*BW-1:0] sb_q[$];
  logic [BW-1:0]   t1_tab [16];

  sobolrng_seq_ctrl #(.BITWIDTH(BW)) dut (
    .iClk   (iClk),
    .iRstN  (iRstN),
    .iStart (iStart),
    .iStop  (iStop),
    .iLen   (iLen),
    .dirVec (dirVec),
    .iReady (iReady),
    .oRand  (oRand),
    .oValid (oValid),
    .oIdx   (oIdx),
    .oBusy  (oBusy),
    .oDone  (oDone)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Gray-code form of the Sobol sequence: x_k = XOR of v_i over set bits of k^(k>>1).
  function automatic logic [BW-1:0] sobol_model(input int k);
    logic [BW-1:0] x;
    int g;
    x = '0;
    g = k ^ (k >> 1);
    for (int i = 0; i < BW; i++) begin
      if (g[i]) x = x ^ dirVec[i*BW +: BW];
    end
    return x;
  endfunction

  task automatic push_model(input int n);
    for (int k = 0; k < n; k++) begin
      sb_q.push_back({BW'(k), sobol_model(k)});
    end
  endtask

  // One clock: drive inputs, check a valid sample against the scoreboard head
  // (popping on handshake), advance to just after the next rising edge.
  task automatic cyc(input logic rdy, input logic st, input logic sp, input logic [BW:0] len);
    logic [2*BW-1:0] e;
    iReady = rdy;
    iStart = st;
    iStop  = sp;
    iLen   = len;
    if (oValid) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_valid", 32'(oValid), 32'd0);
      end else begin
        e = sb_q[0];
        chk("rand", 32'(oRand), 32'(e[BW-1:0]));
        chk("idx", 32'(oIdx), 32'(e[2*BW-1:BW]));
        if (rdy) void'(sb_q.pop_front());
      end
    end
    @(posedge iClk);
    #1;
  endtask

  initial begin
    n_cmp  = 0;
    n_err  = 0;
    iRstN  = 1'b0;
    iStart = 1'b0;
    iStop  = 1'b0;
    iLen   = '0;
    iReady = 1'b0;
    dirVec = 16'h1248;
    t1_tab = '{4'd0, 4'd8, 4'd12, 4'd4, 4'd6, 4'd14, 4'd10, 4'd2,
               4'd3, 4'd11, 4'd15, 4'd7, 4'd5, 4'd13, 4'd9, 4'd1};

    // Reset state
    repeat (3) @(posedge iClk);
    #1;
    chk("rst_rand", 32'(oRand), 32'd0);
    chk("rst_valid", 32'(oValid), 32'd0);
    chk("rst_idx", 32'(oIdx), 32'd0);
    chk("rst_busy", 32'(oBusy), 32'd0);
    chk("rst_done", 32'(oDone), 32'd0);
    iRstN = 1'b1;
    @(posedge iClk);
    #1;

    // 1: full period, iReady held high, fixed expected table
    for (int k = 0; k < 16; k++) sb_q.push_back({BW'(k), t1_tab[k]});
    cyc(1'b0, 1'b1, 1'b0, 5'd16);
    for (int k = 0; k < 16; k++) begin
      chk("t1_thru", 32'(oValid), 32'd1);
      cyc(1'b1, 1'b0, 1'b0, 5'd0);
    end
    chk("t1_done", 32'(oDone), 32'd1);
    chk("t1_valid_off", 32'(oValid), 32'd0);
    chk("t1_busy_off", 32'(oBusy), 32'd0);
    cyc(1'b1, 1'b1, 1'b0, 5'd3);  // start during DONE is ignored
    chk("t1_done_pulse", 32'(oDone), 32'd0);
    chk("t1_idle_valid", 32'(oValid), 32'd0);
    chk("t1_sb_empty", 32'(sb_q.size()), 32'd0);

    // 2: iLen=5, stalls
    push_model(5);
    cyc(1'b0, 1'b1, 1'b0, 5'd5);
    cyc(1'b1, 1'b0, 1'b0, 5'd0);
    cyc(1'b0, 1'b0, 1'b0, 5'd0);
    cyc(1'b0, 1'b0, 1'b0, 5'd0);
    cyc(1'b1, 1'b0, 1'b0, 5'd0);
    cyc(1'b1, 1'b0, 1'b0, 5'd0);
    chk("t2_no_early_done", 32'(oDone), 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 5'd0);
    cyc(1'b1, 1'b0, 1'b0, 5'd0);
    cyc(1'b1, 1'b0, 1'b0, 5'd0);
    chk("t2_done", 32'(oDone), 32'd1);
    chk("t2_sb_empty", 32'(sb_q.size()), 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 5'd0);

    // 3: stop after 3 transfers, then restart with iLen=2
    push_model(16);
    cyc(1'b0, 1'b1, 1'b0, 5'd16);
    repeat (3) cyc(1'b1, 1'b0, 1'b0, 5'd0);
    cyc(1'b0, 1'b0, 1'b1, 5'd0);
    chk("t3_valid_off", 32'(oValid), 32'd0);
    chk("t3_no_done", 32'(oDone), 32'd0);
    chk("t3_left", 32'(sb_q.size()), 32'd13);
    sb_q.delete();
    cyc(1'b0, 1'b0, 1'b0, 5'd0);
    chk("t3_no_done2", 32'(oDone), 32'd0);
    push_model(2);
    cyc(1'b0, 1'b1, 1'b0, 5'd2);
    cyc(1'b1, 1'b0, 1'b0, 5'd0);
    cyc(1'b1, 1'b0, 1'b0, 5'd0);
    chk("t3_done", 32'(oDone), 32'd1);
    chk("t3_sb_empty", 32'(sb_q.size()), 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 5'd0);

    // 4: zero-length start ignored; start during RUN ignored
    cyc(1'b1, 1'b1, 1'b0, 5'd0);
    chk("t4_len0_valid", 32'(oValid), 32'd0);
    chk("t4_len0_busy", 32'(oBusy), 32'd0);
    cyc(1'b1, 1'b0, 1'b0, 5'd0);
    chk("t4_len0_done", 32'(oDone), 32'd0);
    push_model(4);
    cyc(1'b0, 1'b1, 1'b0, 5'd4);
    cyc(1'b1, 1'b0, 1'b0, 5'd0);
    cyc(1'b1, 1'b1, 1'b0, 5'd2);
    cyc(1'b1, 1'b0, 1'b0, 5'd0);
    cyc(1'b1, 1'b0, 1'b0, 5'd0);
    chk("t4_done", 32'(oDone), 32'd1);
    chk("t4_sb_empty", 32'(sb_q.size()), 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 5'd0);

    // 5: iLen=1 with stop+handshake, then iLen=1 plain
    push_model(1);
    cyc(1'b0, 1'b1, 1'b0, 5'd1);
    cyc(1'b1, 1'b0, 1'b1, 5'd0);
    chk("t5_stop_valid", 32'(oValid), 32'd0);
    chk("t5_stop_done", 32'(oDone), 32'd0);
    chk("t5_consumed", 32'(sb_q.size()), 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 5'd0);
    chk("t5_stop_done2", 32'(oDone), 32'd0);
    push_model(1);
    cyc(1'b0, 1'b1, 1'b0, 5'd1);
    cyc(1'b1, 1'b0, 1'b0, 5'd0);
    chk("t5_done", 32'(oDone), 32'd1);
    chk("t5_sb_empty", 32'(sb_q.size()), 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 5'd0);

    // 6: reset mid-run after 7 samples
    push_model(16);
    cyc(1'b0, 1'b1, 1'b0, 5'd16);
    repeat (7) cyc(1'b1, 1'b0, 1'b0, 5'd0);
    iReady = 1'b0;
    iRstN  = 1'b0;
    #1;
    chk("t6_rst_rand", 32'(oRand), 32'd0);
    chk("t6_rst_valid", 32'(oValid), 32'd0);
    chk("t6_rst_idx", 32'(oIdx), 32'd0);
    chk("t6_rst_busy", 32'(oBusy), 32'd0);
    chk("t6_rst_done", 32'(oDone), 32'd0);
    sb_q.delete();
    @(posedge iClk);
    #1;
    iRstN = 1'b1;
    @(posedge iClk);
    #1;
    push_model(3);
    cyc(1'b0, 1'b1, 1'b0, 5'd3);
    repeat (3) cyc(1'b1, 1'b0, 1'b0, 5'd0);
    chk("t6_done", 32'(oDone), 32'd1);
    chk("t6_sb_empty", 32'(sb_q.size()), 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 5'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
